// File: rtl/tick_timer.sv
// Programmable prescaler producing period/half-period ticks, an amber blink level
// and a loadable countdown timer. Define TICK_TIMER_PAUSE_EN to add the `pause` input.
module tick_timer #(
  parameter int CNT_W       = 25,
  parameter int DEFAULT_DIV = 27_000_000,
  parameter int TMR_W       = 8
) (
  input  logic             clk,
  input  logic             devider_reset,
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_value,
  input  logic             timer_load,
  input  logic [TMR_W-1:0] timer_value,
`ifdef TICK_TIMER_PAUSE_EN
  input  logic             pause,
`endif
  output logic             tick,
  output logic             tick_half,
  output logic             blink,
  output logic [TMR_W-1:0] timer_remaining,
  output logic             timer_busy,
  output logic             timer_done
);

  logic             run;
  logic [CNT_W-1:0] div_reg;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] last_cnt;
  logic [CNT_W-1:0] mid_cnt;
  logic [CNT_W-1:0] load_div;
  logic             wrap_ev;
  logic             mid_ev;

`ifdef TICK_TIMER_PAUSE_EN
  assign run = ~pause;
`else
  assign run = 1'b1;
`endif

  // A div_load edge restarts the period, so it suppresses both events on that edge.
  assign last_cnt = div_reg - CNT_W'(1);
  assign mid_cnt  = (div_reg >> 1) - CNT_W'(1);
  assign wrap_ev  = run && !div_load && (cnt == last_cnt);
  assign mid_ev   = run && !div_load && (cnt == mid_cnt);
  assign load_div = (div_value < CNT_W'(2)) ? CNT_W'(2) : div_value;

  always_ff @(posedge clk) begin
    if (devider_reset) begin
      div_reg   <= CNT_W'(DEFAULT_DIV);
      cnt       <= '0;
      tick      <= 1'b0;
      tick_half <= 1'b0;
      blink     <= 1'b0;
    end else begin
      tick      <= wrap_ev;
      tick_half <= wrap_ev | mid_ev;
      if (wrap_ev | mid_ev)
        blink <= ~blink;
      if (div_load) begin
        div_reg <= load_div;
        cnt     <= '0;
      end else if (run) begin
        cnt <= wrap_ev ? '0 : cnt + CNT_W'(1);
      end
    end
  end

  // A load always wins over a same-edge decrement; loading zero reports done at once.
  always_ff @(posedge clk) begin
    if (devider_reset) begin
      timer_remaining <= '0;
      timer_busy      <= 1'b0;
      timer_done      <= 1'b0;
    end else begin
      timer_done <= 1'b0;
      if (timer_load) begin
        timer_remaining <= timer_value;
        timer_busy      <= (timer_value != '0);
        timer_done      <= run && (timer_value == '0);
      end else if (timer_busy && wrap_ev) begin
        timer_remaining <= timer_remaining - TMR_W'(1);
        if (timer_remaining == TMR_W'(1)) begin
          timer_busy <= 1'b0;
          timer_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tick_timer.sv
// Self-checking bench for tick_timer: directed scenarios followed by random traffic,
// compared every cycle against an elapsed-time reference model.
module tb_tick_timer;

  localparam int CNT_W = 8;
  localparam int DEF   = 4;
  localparam int TMR_W = 4;

  logic             clk = 1'b0;
  logic             devider_reset;
  logic             div_load;
  logic [CNT_W-1:0] div_value;
  logic             timer_load;
  logic [TMR_W-1:0] timer_value;
  logic             tick;
  logic             tick_half;
  logic             blink;
  logic [TMR_W-1:0] timer_remaining;
  logic             timer_busy;
  logic             timer_done;

  int checks   = 0;
  int failures = 0;

  // Reference model state: m_t is edges elapsed since the period last restarted.
  int m_t;
  int m_div;
  int m_rem;
  bit m_blink;
  bit m_busy;
  bit e_tick;
  bit e_half;
  bit e_done;

  always #5 clk = ~clk;

  tick_timer #(
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEF),
    .TMR_W       (TMR_W)
  ) dut (
    .clk             (clk),
    .devider_reset   (devider_reset),
    .div_load        (div_load),
    .div_value       (div_value),
    .timer_load      (timer_load),
    .timer_value     (timer_value),
    .tick            (tick),
    .tick_half       (tick_half),
    .blink           (blink),
    .timer_remaining (timer_remaining),
    .timer_busy      (timer_busy),
    .timer_done      (timer_done)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs presented for that edge.
  task automatic modelEdge(input bit rst, input bit dl, input int dv, input bit tl, input int tv);
    if (rst) begin
      m_t = 0; m_div = DEF; m_rem = 0;
      m_blink = 0; m_busy = 0;
      e_tick = 0; e_half = 0; e_done = 0;
    end else begin
      if (dl) begin
        m_div  = (dv < 2) ? 2 : dv;
        m_t    = 0;
        e_tick = 0;
        e_half = 0;
      end else begin
        m_t++;
        e_tick = (m_t % m_div) == 0;
        e_half = e_tick || ((m_t % m_div) == (m_div / 2));
        if (e_half) m_blink = !m_blink;
      end
      e_done = 0;
      if (tl) begin
        if (tv != 0) begin
          m_rem = tv; m_busy = 1;
        end else begin
          m_rem = 0; m_busy = 0; e_done = 1;
        end
      end else if (m_busy && e_tick) begin
        m_rem--;
        if (m_rem == 0) begin
          m_busy = 0; e_done = 1;
        end
      end
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit dl, input int dv, input bit tl, input int tv);
    @(negedge clk);
    devider_reset = rst;
    div_load      = dl;
    div_value     = CNT_W'(dv);
    timer_load    = tl;
    timer_value   = TMR_W'(tv);
    @(posedge clk);
    modelEdge(rst, dl, dv, tl, tv);
    #1;
    checkOutput("tick",      tick,            e_tick);
    checkOutput("tick_half", tick_half,       e_half);
    checkOutput("blink",     blink,           m_blink);
    checkOutput("remaining", timer_remaining, m_rem);
    checkOutput("busy",      timer_busy,      m_busy);
    checkOutput("done",      timer_done,      e_done);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0);
  endtask

  // Step until the next edge is a wrap edge; bounded by one full period.
  task automatic alignToWrap();
    int guard = 0;
    while (((m_t + 1) % m_div) != 0 && guard < 300) begin
      idle(1);
      guard++;
    end
    checkOutput("align_bound", (guard < 300), 1);
  endtask

  initial begin
    devider_reset = 1'b1;
    div_load      = 1'b0;
    div_value     = '0;
    timer_load    = 1'b0;
    timer_value   = '0;

    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);

    // Default period of 4: ticks after edges 4, 8, 12.
    idle(2);
    checkOutput("half_edge2", tick_half, 1);
    checkOutput("blink_edge2", blink, 1);
    idle(2);
    checkOutput("tick_edge4", tick, 1);
    checkOutput("blink_edge4", blink, 0);
    idle(8);

    // Divisor below the minimum clamps to 2.
    applyStimulus(0, 1, 1, 0, 0);
    idle(8);

    // Three-period countdown on a period of 4.
    applyStimulus(0, 1, 4, 0, 0);
    applyStimulus(0, 0, 0, 1, 3);
    idle(16);

    // Zero load: immediate done, never busy.
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("zero_load_done", timer_done, 1);
    idle(2);

    // Load coinciding with a wrap edge is not decremented.
    alignToWrap();
    applyStimulus(0, 0, 0, 1, 5);
    checkOutput("load_on_wrap_rem", timer_remaining, 5);
    idle(24);

    // Reset mid-countdown aborts without a done pulse.
    applyStimulus(0, 0, 0, 1, 3);
    alignToWrap();
    idle(1);
    checkOutput("rem_before_reset", timer_remaining, 2);
    applyStimulus(1, 0, 0, 0, 0);
    idle(4);

    // Reload while busy restarts the countdown.
    applyStimulus(0, 0, 0, 1, 4);
    idle(6);
    applyStimulus(0, 0, 0, 1, 2);
    idle(12);

    // Simultaneous divisor and timer load.
    applyStimulus(0, 1, 3, 1, 2);
    idle(10);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      int r;
      bit rst, dl, tl;
      r   = $urandom_range(0, 99);
      rst = (r < 2);
      dl  = (r >= 2 && r < 7);
      tl  = ($urandom_range(0, 9) == 0);
      applyStimulus(rst, dl, $urandom_range(0, 9), tl, $urandom_range(0, 6));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
